// File: rtl/sram_backup_reader.sv
// sram_backup_reader: streams an SDRAM word region out as big-endian bytes.
// Optional running byte checksum output enabled by SRAM_BACKUP_CHECKSUM_EN.
module sram_backup_reader #(
  parameter int LEN_W       = 18,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [21:0]      base_addr,
  input  logic [LEN_W-1:0] len_bytes,
  output logic [21:0]      mem_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [15:0]      mem_dout,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef SRAM_BACKUP_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HI,
    S_LO,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [15:0]      word;
  logic [TW-1:0]    tcnt;
  logic             ack_ok;
  logic             tmo;
  logic             last;

  assign ack_ok = (mem_ack == mem_req);
  assign tmo    = (ACK_TIMEOUT > 0) && (tcnt == TMAX);
  assign last   = (rem == LEN_W'(1));

  // Dump sequencer: request, wait, emit high byte then low byte, repeat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mem_req   <= mem_ack;
      mem_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rem       <= '0;
      word      <= '0;
      tcnt      <= '0;
`ifdef SRAM_BACKUP_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SRAM_BACKUP_CHECKSUM_EN
      if (out_valid && out_ready)
        checksum <= checksum + {8'd0, out_data};
`endif
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            error    <= 1'b0;
            mem_addr <= base_addr;
            rem      <= len_bytes;
`ifdef SRAM_BACKUP_CHECKSUM_EN
            checksum <= '0;
`endif
            if (len_bytes != '0) begin
              busy  <= 1'b1;
              state <= S_REQ;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_REQ: begin
          tcnt <= '0;
          if (abort) begin
            state <= S_DRAIN;
          end else begin
            mem_req <= ~mem_req;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_DRAIN;
          end else if (ack_ok) begin
            word      <= mem_dout;
            out_data  <= mem_dout[15:8];
            out_valid <= 1'b1;
            state     <= S_HI;
          end else if (tmo) begin
            // leave mem_req as is so a late ack is simply ignored
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_HI: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (out_ready) begin
            rem <= rem - 1'b1;
            if (last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_FIN;
            end else begin
              out_data <= word[7:0];
              state    <= S_LO;
            end
          end
        end
        S_LO: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (out_ready) begin
            rem       <= rem - 1'b1;
            mem_addr  <= mem_addr + 22'd1;
            out_valid <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (ack_ok) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmo) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_backup_reader.sv
// tb_sram_backup_reader: directed vectors and corner sequences for
// sram_backup_reader, with a toggle-protocol SDRAM responder model.
module tb_sram_backup_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [21:0] base_addr;
  logic [17:0] len_bytes;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b1;
  logic [15:0] mem_dout = 16'h0000;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  logic        t_start;
  logic        t_ack = 1'b0;
  logic [21:0] t_addr;
  logic        t_req;
  logic [7:0]  t_data;
  logic        t_valid;
  logic        t_busy;
  logic        t_done;
  logic        t_error;
  logic [15:0] t_csum;

  always #5 clk = ~clk;

  sram_backup_reader dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .len_bytes (len_bytes),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
`ifdef SRAM_BACKUP_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  sram_backup_reader #(.ACK_TIMEOUT(16)) dut_t (
    .clk       (clk),
    .resetn    (resetn),
    .start     (t_start),
    .abort     (1'b0),
    .base_addr (base_addr),
    .len_bytes (len_bytes),
    .mem_addr  (t_addr),
    .mem_req   (t_req),
    .mem_ack   (t_ack),
    .mem_dout  (mem_dout),
    .out_data  (t_data),
    .out_valid (t_valid),
    .out_ready (out_ready),
    .busy      (t_busy),
    .done      (t_done),
    .error     (t_error)
`ifdef SRAM_BACKUP_CHECKSUM_EN
    ,
    .checksum  (t_csum)
`endif
  );

`ifndef SRAM_BACKUP_CHECKSUM_EN
  assign checksum = 16'h0;
  assign t_csum   = 16'h0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [21:0] a);
    if (a == 22'h010000) return 16'h1234;
    if (a == 22'h010001) return 16'hABCD;
    return {a[7:0], ~a[7:0]};
  endfunction

  // SDRAM responder: completes a pending toggle after ack_delay cycles
  int ack_delay = 2;
  int dly = 0;
  always @(negedge clk) begin
    if (resetn && mem_req != mem_ack) begin
      if (dly >= ack_delay) begin
        mem_dout = memf(mem_addr);
        mem_ack  = mem_req;
        dly      = 0;
      end else begin
        dly++;
      end
    end
  end

  // Monitor: records accepted bytes, toggles and done pulses
  logic [7:0]  bytes[$];
  logic [21:0] tog_addr[$];
  int tog_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int last_byte_cyc = 0, done_cyc = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        bytes.push_back(out_data);
        last_byte_cyc = cyc;
      end
      if (out_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_req != prev_req) begin
        tog_cnt++;
        tog_addr.push_back(mem_addr);
      end
    end
    prev_req = mem_req;
  end

  typedef struct {
    logic [21:0] base;
    logic [17:0] len;
    int          nb;
    logic [31:0] b;
    int          ntog;
    logic [21:0] a0;
    logic [21:0] a1;
    logic [15:0] csum;
  } vec_t;

  vec_t vt[6];

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no done within 300 cycles", name);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int b0, t0, d0, v0, ta0, sc;
    logic [31:0] bw;
    string nm;
    nm = $sformatf("vec%0d", idx);
    bw = v.b;
    b0 = bytes.size(); t0 = tog_cnt; d0 = done_cnt;
    v0 = valid_cnt; ta0 = tog_addr.size();
    @(posedge clk); #1;
    base_addr = v.base; len_bytes = v.len; start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, nm);
    repeat (5) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
    chk({nm, "_nbytes"}, bytes.size() - b0, v.nb);
    for (int j = 0; j < v.nb && b0 + j < bytes.size(); j++)
      chk($sformatf("%s_byte%0d", nm, j), bytes[b0 + j], bw[31 - 8*j -: 8]);
    chk({nm, "_ntog"}, tog_cnt - t0, v.ntog);
    if (v.ntog > 0 && tog_addr.size() > ta0)
      chk({nm, "_addr0"}, tog_addr[ta0], v.a0);
    if (v.ntog > 1 && tog_addr.size() > ta0 + 1)
      chk({nm, "_addr1"}, tog_addr[ta0 + 1], v.a1);
    if (v.nb == 0) begin
      chk({nm, "_valid_cnt"}, valid_cnt - v0, 0);
      chk({nm, "_done_lat"}, done_cyc - sc, 1);
    end else begin
      chk({nm, "_done_lat"}, done_cyc - last_byte_cyc, 1);
    end
    chk({nm, "_busy"}, busy, 0);
`ifdef SRAM_BACKUP_CHECKSUM_EN
    chk({nm, "_csum"}, checksum, v.csum);
`endif
  endtask

  task automatic pulse_start(input logic [21:0] b, input logic [17:0] l);
    @(posedge clk); #1;
    base_addr = b; len_bytes = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, t0, d0, k, bad, tc, ec, tdn;
    logic pr;
    vt[0] = '{22'h010000, 18'd4, 4, 32'h1234ABCD, 2, 22'h010000, 22'h010001, 16'h01BE};
    vt[1] = '{22'h010000, 18'd3, 3, 32'h1234AB00, 2, 22'h010000, 22'h010001, 16'h00F1};
    vt[2] = '{22'h010000, 18'd2, 2, 32'h12340000, 1, 22'h010000, 22'h000000, 16'h0046};
    vt[3] = '{22'h010001, 18'd1, 1, 32'hAB000000, 1, 22'h010001, 22'h000000, 16'h00AB};
    vt[4] = '{22'h010000, 18'd0, 0, 32'h00000000, 0, 22'h000000, 22'h000000, 16'h0000};
    vt[5] = '{22'h3FFFFF, 18'd4, 4, 32'hFF0000FF, 2, 22'h3FFFFF, 22'h000000, 16'h01FE};

    resetn = 1'b0; start = 1'b0; abort = 1'b0; t_start = 1'b0;
    out_ready = 1'b1; base_addr = '0; len_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_t_req", t_req, 0);
    chk("rst_t_error", t_error, 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // backpressure: first byte must hold while out_ready is low
    out_ready = 1'b0;
    b0 = bytes.size(); d0 = done_cnt;
    pulse_start(22'h010000, 18'd2);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_valid_seen", out_valid, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && out_data == 8'h12)) bad++;
    end
    chk("hold_stable", bad, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(d0, "hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_nbytes", bytes.size() - b0, 2);
    if (bytes.size() >= b0 + 2) begin
      chk("hold_b0", bytes[b0], 8'h12);
      chk("hold_b1", bytes[b0 + 1], 8'h34);
    end
    chk("hold_done", done_cnt - d0, 1);

    // abort while waiting on the first word with a slow ack
    ack_delay = 20;
    b0 = bytes.size(); t0 = tog_cnt; d0 = done_cnt;
    pulse_start(22'h010000, 18'd4);
    k = 0;
    while (tog_cnt == t0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bad = 0; k = 0;
    while (mem_ack != mem_req && k < 100) begin
      if (!busy) bad++;
      @(posedge clk); #1;
      k++;
    end
    chk("abort_busy_held", bad, 0);
    chk("abort_drained", mem_ack == mem_req, 1);
    chk("abort_busy_low", busy, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_ntog", tog_cnt - t0, 1);
    chk("abort_nbytes", bytes.size() - b0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    ack_delay = 2;
    run_vec(vt[2], 10);

    // abort together with start in idle: nothing starts
    t0 = tog_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 22'h010000; len_bytes = 18'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("sa_ntog", tog_cnt - t0, 0);
    chk("sa_no_done", done_cnt - d0, 0);

    // abort while presenting the high byte
    out_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(22'h010000, 18'd4);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ahi_valid", out_valid, 0);
    chk("ahi_busy", busy, 0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ahi_no_done", done_cnt - d0, 0);
    run_vec(vt[0], 11);

    // ack timeout on the instance with ACK_TIMEOUT = 16
    tc = -1; ec = -1; tdn = 0; pr = t_req;
    @(posedge clk); #1;
    base_addr = 22'h000100; len_bytes = 18'd4; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (t_req != pr && tc < 0) tc = cyc;
      if (t_done) tdn++;
      if (t_error) begin
        ec = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("tmo_error_set", ec >= 0, 1);
    chk("tmo_latency", ec - tc, 16);
    chk("tmo_busy", t_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    if (t_done) tdn++;
    chk("tmo_no_done", tdn, 0);
    @(posedge clk); #1;
    len_bytes = 18'd0; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    chk("tmo_error_cleared", t_error, 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
